pc_redirect_controller: RTL and testbench

//  Sequences PC update and pipeline-register control for the MIPS pipeline.

---
 rtl/mips_ctrl_pkg.sv | 20 ++
 rtl/pc_redirect_controller_if.sv | 34 +++
 rtl/redirect_priority_encoder.sv | 31 +++
 rtl/pc_redirect_controller.sv | 133 +++++++++++++
 tb/tb_pc_redirect_controller.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared constants for the MIPS PC redirect controller: FSM state codes and
// next-PC select codes, plus the request-select bundle of the priority encoder.
package mips_ctrl_pkg;

    localparam logic [1:0] RUN   = 2'd0;
    localparam logic [1:0] STALL = 2'd1;
    localparam logic [1:0] FLUSH = 2'd2;

    localparam logic [1:0] SEL_SEQ = 2'd0;
    localparam logic [1:0] SEL_BR  = 2'd1;
    localparam logic [1:0] SEL_JR  = 2'd2;
    localparam logic [1:0] SEL_J   = 2'd3;

    typedef struct packed {
        logic [1:0] sel;
        logic       redirect;
        logic       stall;
    } req_sel_t;

endpackage

// File: rtl/pc_redirect_controller_if.sv
// Request/target bundle from the hazard and branch logic, and the PC /
// pipeline-register controls returned by the redirect controller.
interface pc_redirect_controller_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  branch_eq_i;
    logic                  branch_ne_i;
    logic                  jump_reg_i;
    logic                  jump_i;
    logic                  load_use_i;
    logic [DATA_WIDTH-1:0] pc_plus4_i;
    logic [DATA_WIDTH-1:0] branch_target_i;
    logic [DATA_WIDTH-1:0] jr_target_i;
    logic [DATA_WIDTH-1:0] jump_target_i;
    logic [DATA_WIDTH-1:0] next_pc_o;
    logic                  pc_write_o;
    logic                  if_id_write_o;
    logic                  if_id_flush_o;
    logic                  id_ex_flush_o;
    logic [1:0]            state_o;

    modport master (
        output branch_eq_i, branch_ne_i, jump_reg_i, jump_i, load_use_i,
        output pc_plus4_i, branch_target_i, jr_target_i, jump_target_i,
        input  next_pc_o, pc_write_o, if_id_write_o, if_id_flush_o, id_ex_flush_o, state_o
    );

    modport slave (
        input  branch_eq_i, branch_ne_i, jump_reg_i, jump_i, load_use_i,
        input  pc_plus4_i, branch_target_i, jr_target_i, jump_target_i,
        output next_pc_o, pc_write_o, if_id_write_o, if_id_flush_o, id_ex_flush_o, state_o
    );

endinterface

// File: rtl/redirect_priority_encoder.sv
// Fixed-priority arbitration of control-flow requests:
// branch > jump_reg > jump > load_use; lower requests in the same cycle are dropped.
module redirect_priority_encoder
    import mips_ctrl_pkg::*;
(
    input  logic     branch,
    input  logic     jump_reg,
    input  logic     jump,
    input  logic     load_use,
    output req_sel_t req
);

    always_comb begin
        req.sel      = SEL_SEQ;
        req.redirect = 1'b0;
        req.stall    = 1'b0;
        if (branch) begin
            req.sel      = SEL_BR;
            req.redirect = 1'b1;
        end else if (jump_reg) begin
            req.sel      = SEL_JR;
            req.redirect = 1'b1;
        end else if (jump) begin
            req.sel      = SEL_J;
            req.redirect = 1'b1;
        end else if (load_use) begin
            req.stall    = 1'b1;
        end
    end

endmodule

// File: rtl/pc_redirect_controller.sv
// PC / pipeline-register sequencer for the MIPS pipeline.
// Optional statistics counters are built when PC_REDIRECT_STATS_EN is defined.
//   state | meaning
//   RUN   | normal fetch; redirects and load-use stalls are accepted
//   STALL | load-use bubble in progress; only a taken branch can abort it
//   FLUSH | post-redirect flush; every request comes from a squashed instr
module pc_redirect_controller
    import mips_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int FLUSH_CYCLES = 1,
    parameter int STALL_CYCLES = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    pc_redirect_controller_if.slave ctrl
`ifdef PC_REDIRECT_STATS_EN
    ,
    output logic [31:0]             redirect_cnt_o,
    output logic [31:0]             stall_cnt_o
`endif
);

    localparam int MAX_CYCLES = (FLUSH_CYCLES > STALL_CYCLES) ? FLUSH_CYCLES : STALL_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES) + 1;
    localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FLUSH_CYCLES - 1);
    localparam logic [CNT_W-1:0] STALL_LOAD = CNT_W'(STALL_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    logic [1:0]            state, state_nxt;
    logic [CNT_W-1:0]      cnt, cnt_nxt;
    logic                  in_stall, in_flush, in_run;
    logic [DATA_WIDTH-1:0] next_pc;
    logic                  pc_write, if_id_write, if_id_flush, id_ex_flush;
    req_sel_t              req;

    assign in_stall = (state == STALL);
    assign in_flush = (state == FLUSH);
    assign in_run   = !in_stall && !in_flush;

    // A taken branch is the only request honoured while the ID instr is frozen.
    redirect_priority_encoder u_prio (
        .branch   ((ctrl.branch_eq_i | ctrl.branch_ne_i) & ~in_flush),
        .jump_reg (ctrl.jump_reg_i & in_run),
        .jump     (ctrl.jump_i & in_run),
        .load_use (ctrl.load_use_i & in_run),
        .req      (req)
    );

    always_comb begin
        next_pc     = ctrl.pc_plus4_i;
        pc_write    = 1'b1;
        if_id_write = 1'b1;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        if (reset) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
        end else if (in_flush) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (req.redirect) begin
            if_id_flush = 1'b1;
            id_ex_flush = (req.sel == SEL_BR);
            case (req.sel)
                SEL_BR:  next_pc = ctrl.branch_target_i;
                SEL_JR:  next_pc = ctrl.jr_target_i;
                SEL_J:   next_pc = ctrl.jump_target_i;
                default: next_pc = ctrl.pc_plus4_i;
            endcase
        end else if (req.stall || in_stall) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_flush = 1'b1;
        end
    end

    always_comb begin
        state_nxt = RUN;
        cnt_nxt   = '0;
        if (req.redirect) begin
            if (FLUSH_CYCLES > 1) begin
                state_nxt = FLUSH;
                cnt_nxt   = FLUSH_LOAD;
            end
        end else if (in_flush || in_stall) begin
            if (cnt > CNT_ONE) begin
                state_nxt = state;
                cnt_nxt   = cnt - CNT_ONE;
            end
        end else if (req.stall) begin
            if (STALL_CYCLES > 1) begin
                state_nxt = STALL;
                cnt_nxt   = STALL_LOAD;
            end
        end
        // Unused encoding recovers to RUN unconditionally.
        if (state == 2'd3) begin
            state_nxt = RUN;
            cnt_nxt   = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    assign ctrl.next_pc_o     = next_pc;
    assign ctrl.pc_write_o    = pc_write;
    assign ctrl.if_id_write_o = if_id_write;
    assign ctrl.if_id_flush_o = if_id_flush;
    assign ctrl.id_ex_flush_o = id_ex_flush;
    assign ctrl.state_o       = state;

`ifdef PC_REDIRECT_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            redirect_cnt_o <= '0;
            stall_cnt_o    <= '0;
        end else begin
            if (req.redirect) redirect_cnt_o <= redirect_cnt_o + 32'd1;
            if (!pc_write)    stall_cnt_o    <= stall_cnt_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pc_redirect_controller.sv
// Directed bench: dut_a uses single-cycle flush/stall, dut_b uses FLUSH_CYCLES=3, STALL_CYCLES=2.
module tb_pc_redirect_controller;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    pc_redirect_controller_if #(.DATA_WIDTH(32)) if_a ();
    pc_redirect_controller_if #(.DATA_WIDTH(32)) if_b ();

`ifdef PC_REDIRECT_STATS_EN
    logic [31:0] red_a, stl_a, red_b, stl_b;
`endif

    pc_redirect_controller #(.DATA_WIDTH(32), .FLUSH_CYCLES(1), .STALL_CYCLES(1)) dut_a (
        .clk   (clk),
        .reset (reset),
        .ctrl  (if_a)
`ifdef PC_REDIRECT_STATS_EN
        ,
        .redirect_cnt_o (red_a),
        .stall_cnt_o    (stl_a)
`endif
    );

    pc_redirect_controller #(.DATA_WIDTH(32), .FLUSH_CYCLES(3), .STALL_CYCLES(2)) dut_b (
        .clk   (clk),
        .reset (reset),
        .ctrl  (if_b)
`ifdef PC_REDIRECT_STATS_EN
        ,
        .redirect_cnt_o (red_b),
        .stall_cnt_o    (stl_b)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_inputs();
        if_a.branch_eq_i = 0; if_a.branch_ne_i = 0; if_a.jump_reg_i = 0; if_a.jump_i = 0; if_a.load_use_i = 0;
        if_b.branch_eq_i = 0; if_b.branch_ne_i = 0; if_b.jump_reg_i = 0; if_b.jump_i = 0; if_b.load_use_i = 0;
        if_a.pc_plus4_i = 32'h0040_0004; if_a.branch_target_i = 32'h0040_0abc;
        if_a.jr_target_i = 32'h0040_0def; if_a.jump_target_i = 32'h0040_0f00;
        if_b.pc_plus4_i = 32'h0040_0104; if_b.branch_target_i = 32'h0040_0100;
        if_b.jr_target_i = 32'h0040_0200; if_b.jump_target_i = 32'h0040_8000;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        if_a.branch_eq_i = 1;
        @(negedge clk); #1;
        checks++; if (if_a.pc_write_o !== 1'b0) begin failures++; $display("FAIL rst_pc_write got %b exp 0", if_a.pc_write_o); end
        checks++; if (if_a.if_id_write_o !== 1'b0) begin failures++; $display("FAIL rst_if_id_write got %b exp 0", if_a.if_id_write_o); end
        checks++; if (if_a.if_id_flush_o !== 1'b0 || if_a.id_ex_flush_o !== 1'b0) begin failures++; $display("FAIL rst_flush got %b%b exp 00", if_a.if_id_flush_o, if_a.id_ex_flush_o); end
        checks++; if (if_a.next_pc_o !== 32'h0040_0004) begin failures++; $display("FAIL rst_next_pc got %h exp 00400004", if_a.next_pc_o); end
        checks++; if (if_a.state_o !== 2'd0 || if_b.state_o !== 2'd0) begin failures++; $display("FAIL rst_state got %0d/%0d exp 0/0", if_a.state_o, if_b.state_o); end
        @(negedge clk);
        reset = 1'b0;
        if_a.branch_eq_i = 0;
        #1;
        checks++; if (if_a.pc_write_o !== 1'b1 || if_a.next_pc_o !== 32'h0040_0004) begin failures++; $display("FAIL rel_seq got pw=%b pc=%h exp pw=1 pc=00400004", if_a.pc_write_o, if_a.next_pc_o); end
        checks++; if (if_a.if_id_write_o !== 1'b1 || if_a.id_ex_flush_o !== 1'b0) begin failures++; $display("FAIL rel_ctrl got ifw=%b idex=%b exp 1 0", if_a.if_id_write_o, if_a.id_ex_flush_o); end
    endtask

    task automatic test_branch_priority();
        @(negedge clk);
        idle_inputs();
        if_a.pc_plus4_i = 32'h0040_0008;
        if_a.branch_target_i = 32'h0040_0020;
        if_a.jump_target_i = 32'h0040_9000;
        if_a.branch_ne_i = 1; if_a.jump_i = 1;
        #1;
        checks++; if (if_a.next_pc_o !== 32'h0040_0020) begin failures++; $display("FAIL br_next_pc got %h exp 00400020", if_a.next_pc_o); end
        checks++; if (if_a.if_id_flush_o !== 1'b1 || if_a.id_ex_flush_o !== 1'b1) begin failures++; $display("FAIL br_flush got %b%b exp 11", if_a.if_id_flush_o, if_a.id_ex_flush_o); end
        checks++; if (if_a.pc_write_o !== 1'b1) begin failures++; $display("FAIL br_pc_write got %b exp 1", if_a.pc_write_o); end
        @(negedge clk);
        if_a.branch_ne_i = 0; if_a.jump_i = 0;
        #1;
        checks++; if (if_a.state_o !== 2'd0 || if_a.next_pc_o !== 32'h0040_0008 || if_a.if_id_flush_o !== 1'b0) begin failures++; $display("FAIL br_after got st=%0d pc=%h iff=%b exp 0 00400008 0", if_a.state_o, if_a.next_pc_o, if_a.if_id_flush_o); end
    endtask

    task automatic test_jr_over_load_use();
        @(negedge clk);
        if_a.jr_target_i = 32'h0040_1000;
        if_a.jump_reg_i = 1; if_a.load_use_i = 1;
        #1;
        checks++; if (if_a.next_pc_o !== 32'h0040_1000) begin failures++; $display("FAIL jr_next_pc got %h exp 00401000", if_a.next_pc_o); end
        checks++; if (if_a.if_id_flush_o !== 1'b1 || if_a.id_ex_flush_o !== 1'b0) begin failures++; $display("FAIL jr_flush got %b%b exp 10", if_a.if_id_flush_o, if_a.id_ex_flush_o); end
        checks++; if (if_a.pc_write_o !== 1'b1) begin failures++; $display("FAIL jr_pc_write got %b exp 1", if_a.pc_write_o); end
        @(negedge clk);
        if_a.jump_reg_i = 0; if_a.load_use_i = 0;
        #1;
        checks++; if (if_a.state_o !== 2'd0 || if_a.pc_write_o !== 1'b1) begin failures++; $display("FAIL jr_no_stall got st=%0d pw=%b exp 0 1", if_a.state_o, if_a.pc_write_o); end
    endtask

    task automatic test_load_use_single();
        @(negedge clk);
        if_a.load_use_i = 1;
        #1;
        checks++; if (if_a.pc_write_o !== 1'b0 || if_a.if_id_write_o !== 1'b0) begin failures++; $display("FAIL lu1_hold got pw=%b ifw=%b exp 0 0", if_a.pc_write_o, if_a.if_id_write_o); end
        checks++; if (if_a.id_ex_flush_o !== 1'b1 || if_a.if_id_flush_o !== 1'b0) begin failures++; $display("FAIL lu1_flush got idex=%b iff=%b exp 1 0", if_a.id_ex_flush_o, if_a.if_id_flush_o); end
        @(negedge clk);
        if_a.load_use_i = 0;
        #1;
        checks++; if (if_a.state_o !== 2'd0 || if_a.pc_write_o !== 1'b1) begin failures++; $display("FAIL lu1_after got st=%0d pw=%b exp 0 1", if_a.state_o, if_a.pc_write_o); end
    endtask

    task automatic test_stall_multi();
        @(negedge clk);
        if_b.load_use_i = 1;
        #1;
        checks++; if (if_b.pc_write_o !== 1'b0 || if_b.id_ex_flush_o !== 1'b1 || if_b.state_o !== 2'd0) begin failures++; $display("FAIL st2_c0 got pw=%b idex=%b st=%0d exp 0 1 0", if_b.pc_write_o, if_b.id_ex_flush_o, if_b.state_o); end
        @(negedge clk);
        if_b.load_use_i = 0;
        #1;
        checks++; if (if_b.pc_write_o !== 1'b0 || if_b.id_ex_flush_o !== 1'b1 || if_b.state_o !== 2'd1) begin failures++; $display("FAIL st2_c1 got pw=%b idex=%b st=%0d exp 0 1 1", if_b.pc_write_o, if_b.id_ex_flush_o, if_b.state_o); end
        @(negedge clk); #1;
        checks++; if (if_b.pc_write_o !== 1'b1 || if_b.id_ex_flush_o !== 1'b0 || if_b.state_o !== 2'd0) begin failures++; $display("FAIL st2_end got pw=%b idex=%b st=%0d exp 1 0 0", if_b.pc_write_o, if_b.id_ex_flush_o, if_b.state_o); end
    endtask

    task automatic test_stall_branch_abort();
        @(negedge clk);
        if_b.load_use_i = 1;
        @(negedge clk);
        if_b.load_use_i = 0;
        if_b.branch_eq_i = 1;
        #1;
        checks++; if (if_b.state_o !== 2'd1 || if_b.next_pc_o !== 32'h0040_0100 || if_b.pc_write_o !== 1'b1) begin failures++; $display("FAIL abort_redir got st=%0d pc=%h pw=%b exp 1 00400100 1", if_b.state_o, if_b.next_pc_o, if_b.pc_write_o); end
        @(negedge clk);
        if_b.branch_eq_i = 0;
        #1;
        checks++; if (if_b.state_o !== 2'd2) begin failures++; $display("FAIL abort_flush got st=%0d exp 2", if_b.state_o); end
        @(negedge clk);
        @(negedge clk); #1;
        checks++; if (if_b.state_o !== 2'd0 || if_b.if_id_flush_o !== 1'b0) begin failures++; $display("FAIL abort_end got st=%0d iff=%b exp 0 0", if_b.state_o, if_b.if_id_flush_o); end
    endtask

    task automatic test_flush_multi();
        @(negedge clk);
        if_b.branch_eq_i = 1;
        #1;
        checks++; if (if_b.next_pc_o !== 32'h0040_0100 || if_b.if_id_flush_o !== 1'b1 || if_b.id_ex_flush_o !== 1'b1) begin failures++; $display("FAIL fl3_c0 got pc=%h flush=%b%b exp 00400100 11", if_b.next_pc_o, if_b.if_id_flush_o, if_b.id_ex_flush_o); end
        @(negedge clk);
        if_b.branch_eq_i = 0; if_b.jump_i = 1;
        #1;
        checks++; if (if_b.state_o !== 2'd2 || if_b.next_pc_o !== 32'h0040_0104 || if_b.pc_write_o !== 1'b1) begin failures++; $display("FAIL fl3_c1 got st=%0d pc=%h pw=%b exp 2 00400104 1", if_b.state_o, if_b.next_pc_o, if_b.pc_write_o); end
        checks++; if (if_b.if_id_flush_o !== 1'b1 || if_b.id_ex_flush_o !== 1'b1) begin failures++; $display("FAIL fl3_c1_flush got %b%b exp 11", if_b.if_id_flush_o, if_b.id_ex_flush_o); end
        @(negedge clk); #1;
        checks++; if (if_b.state_o !== 2'd2 || if_b.next_pc_o !== 32'h0040_0104 || if_b.if_id_flush_o !== 1'b1) begin failures++; $display("FAIL fl3_c2 got st=%0d pc=%h iff=%b exp 2 00400104 1", if_b.state_o, if_b.next_pc_o, if_b.if_id_flush_o); end
        @(negedge clk);
        if_b.jump_i = 0;
        #1;
        checks++; if (if_b.state_o !== 2'd0 || if_b.if_id_flush_o !== 1'b0 || if_b.next_pc_o !== 32'h0040_0104) begin failures++; $display("FAIL fl3_end got st=%0d iff=%b pc=%h exp 0 0 00400104", if_b.state_o, if_b.if_id_flush_o, if_b.next_pc_o); end
    endtask

`ifdef PC_REDIRECT_STATS_EN
    task automatic test_stats();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        idle_inputs();
        @(negedge clk); if_a.branch_eq_i = 1;
        @(negedge clk); if_a.branch_eq_i = 0; if_a.jump_i = 1;
        @(negedge clk); if_a.jump_i = 0; if_a.jump_reg_i = 1;
        @(negedge clk); if_a.jump_reg_i = 0; if_a.load_use_i = 1;
        @(negedge clk);
        @(negedge clk); if_a.load_use_i = 0;
        #1;
        checks++; if (red_a !== 32'd3) begin failures++; $display("FAIL stats_redirect got %0d exp 3", red_a); end
        checks++; if (stl_a !== 32'd2) begin failures++; $display("FAIL stats_stall got %0d exp 2", stl_a); end
    endtask
`endif

    task automatic test_reset_mid_flush();
        @(negedge clk);
        if_b.branch_eq_i = 1;
        @(negedge clk);
        if_b.branch_eq_i = 0;
        #1;
        checks++; if (if_b.state_o !== 2'd2) begin failures++; $display("FAIL mid_pre got st=%0d exp 2", if_b.state_o); end
        #2 reset = 1'b1;
        #1;
        checks++; if (if_b.state_o !== 2'd0 || if_b.pc_write_o !== 1'b0 || if_b.if_id_flush_o !== 1'b0) begin failures++; $display("FAIL mid_rst got st=%0d pw=%b iff=%b exp 0 0 0", if_b.state_o, if_b.pc_write_o, if_b.if_id_flush_o); end
`ifdef PC_REDIRECT_STATS_EN
        checks++; if (red_a !== 32'd0 || stl_a !== 32'd0 || red_b !== 32'd0) begin failures++; $display("FAIL mid_stats got %0d %0d %0d exp 0 0 0", red_a, stl_a, red_b); end
`endif
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++; if (if_b.state_o !== 2'd0 || if_b.pc_write_o !== 1'b1 || if_b.if_id_flush_o !== 1'b0) begin failures++; $display("FAIL mid_rel got st=%0d pw=%b iff=%b exp 0 1 0", if_b.state_o, if_b.pc_write_o, if_b.if_id_flush_o); end
        checks++; if (if_b.next_pc_o !== 32'h0040_0104) begin failures++; $display("FAIL mid_rel_pc got %h exp 00400104", if_b.next_pc_o); end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_branch_priority();
        test_jr_over_load_use();
        test_load_use_single();
        test_stall_multi();
        test_stall_branch_abort();
        test_flush_multi();
`ifdef PC_REDIRECT_STATS_EN
        test_stats();
`endif
        test_reset_mid_flush();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
